// File: rtl/defuzz.sv
// -----------------------------------------------------------------------------
// defuzz -- output stage of the fuzzy controller.
//
// Converts the aggregated weighted-sum pair into a crisp integer percentage:
//   G = floor(floor((S_wg << 15) / max(S_w, EPS)) * 100 / 2^15),
// clamped to 0..100 and registered.
//
// Handshake: none. There is no valid/ready pair; the inputs are sampled on
// every rising edge of clk and the result appears on G_out just after that
// edge (one cycle of latency). A new result is produced every cycle.
//
// Ports:
//   clk    in   1   system clock, rising-edge active
//   rst_n  in   1   synchronous active-low reset (G_out <= 0)
//   S_w    in  16   sum of rule weights, unsigned Q1.15
//   S_wg   in  16   sum of weight x consequent, unsigned Q1.15
//   G_out  out  8   crisp output, unsigned integer percent 0..100
// -----------------------------------------------------------------------------
module defuzz #(
    parameter logic [15:0] EPS = 16'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] S_w,
    input  logic [15:0] S_wg,
    output logic [7:0]  G_out
);

    logic [15:0] den;
    logic [30:0] num;
    logic [30:0] ratio;
    logic [37:0] prod;
    logic [22:0] pct;
    logic [7:0]  g_next;

    // Denominator floor keeps the divide defined when S_w is (near) zero.
    assign den = (S_w < EPS) ? EPS : S_w;
    assign num = {S_wg, 15'd0};

    // Restoring long division, one quotient bit per numerator bit, MSB first.
    // The remainder is always < den before the shift, so it fits in 17 bits
    // after shifting in the next numerator bit.
    logic [16:0] rem;
    always_comb begin
        rem   = 17'd0;
        ratio = 31'd0;
        for (int i = 30; i >= 0; i--) begin
            rem = {rem[15:0], num[i]};
            if (rem >= {1'b0, den}) begin
                rem      = rem - {1'b0, den};
                ratio[i] = 1'b1;
            end
        end
    end

    // 31-bit ratio times 100 needs 38 bits to avoid any wrap.
    assign prod = {7'd0, ratio} * 38'd100;
    assign pct  = 23'(prod >> 15);

    assign g_next = (pct > 23'd100) ? 8'd100 : pct[7:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            G_out <= 8'd0;
        end else begin
            G_out <= g_next;
        end
    end

endmodule

// File: tb/tb_defuzz.sv
// -----------------------------------------------------------------------------
// tb_defuzz -- self-checking bench for defuzz.
// Inputs change on the falling edge; the expected value for each cycle is
// pushed to exp_q when the stimulus is driven and popped after the next
// rising edge (sampled #1 later) for comparison.
// -----------------------------------------------------------------------------
module tb_defuzz;

    localparam logic [15:0] EPS = 16'd1;

    logic        clk;
    logic        rst_n;
    logic [15:0] S_w;
    logic [15:0] S_wg;
    logic [7:0]  G_out;

    logic [7:0] exp_q[$];

    int compared;
    int mismatched;

    defuzz #(.EPS(EPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .S_w   (S_w),
        .S_wg  (S_wg),
        .G_out (G_out)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: straightforward 64-bit integer arithmetic.
    function automatic logic [7:0] ref_g(input logic [15:0] w, input logic [15:0] wg);
        longint unsigned d, r, p;
        d = (w < EPS) ? longint'(EPS) : longint'(w);
        r = (longint'(wg) << 15) / d;
        p = (r * 100) >> 15;
        return (p > 100) ? 8'd100 : p[7:0];
    endfunction

    // Driver: apply one cycle of stimulus at the falling edge, record what
    // G_out must be after the next rising edge, then move to the sample point.
    task automatic drive(input logic rst, input logic [15:0] w, input logic [15:0] wg);
        @(negedge clk);
        rst_n = rst;
        S_w   = w;
        S_wg  = wg;
        exp_q.push_back(rst ? ref_g(w, wg) : 8'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'd0, 16'd0);
            e = exp_q.pop_front();
            compared++;
            if (G_out !== e) begin
                mismatched++;
                $display("FAIL reset_hold[%0d]: got %0d expected %0d", i, G_out, e);
            end
        end
        drive(1'b1, 16'd0, 16'd0);
        e = exp_q.pop_front();
        compared++;
        if (G_out !== e) begin
            mismatched++;
            $display("FAIL zero_after_release: got %0d expected %0d", G_out, e);
        end
    endtask

    task automatic test_vectors(input string name, input logic [15:0] w[],
                                input logic [15:0] wg[], input logic [7:0] req[]);
        logic [7:0] e;
        for (int i = 0; i < w.size(); i++) begin
            drive(1'b1, w[i], wg[i]);
            e = exp_q.pop_front();
            compared++;
            if (G_out !== e || G_out !== req[i]) begin
                mismatched++;
                $display("FAIL %s[%0d] (S_w=%0d S_wg=%0d): got %0d expected %0d (table %0d)",
                         name, i, w[i], wg[i], G_out, e, req[i]);
            end
        end
    endtask

    task automatic test_nominal();
        test_vectors("nominal", '{16'd32767, 16'd32767, 16'd20000},
                                '{16'd16384, 16'd32767, 16'd10000},
                                '{8'd50, 8'd100, 8'd50});
    endtask

    task automatic test_truncation();
        test_vectors("truncation", '{16'd30000, 16'd30000},
                                   '{16'd14999, 16'd15000},
                                   '{8'd49, 8'd50});
    endtask

    task automatic test_saturation();
        test_vectors("saturation", '{16'd10000, 16'd1, 16'd1, 16'd0, 16'd65535, 16'd0},
                                   '{16'd30000, 16'd32767, 16'd0, 16'd5, 16'd65535, 16'd0},
                                   '{8'd100, 8'd100, 8'd0, 8'd100, 8'd100, 8'd0});
    endtask

    task automatic test_random();
        logic [7:0]  e;
        logic [15:0] w, wg;
        for (int i = 0; i < 32; i++) begin
            w  = 16'($urandom_range(32767, 0));
            wg = 16'($urandom_range(int'(w), 0));
            drive(1'b1, w, wg);
            e = exp_q.pop_front();
            compared++;
            if (G_out !== e) begin
                mismatched++;
                $display("FAIL random[%0d] (S_w=%0d S_wg=%0d): got %0d expected %0d",
                         i, w, wg, G_out, e);
            end
            compared++;
            if (!(G_out <= 8'd100)) begin
                mismatched++;
                $display("FAIL random_range[%0d]: got %0d expected <= 100", i, G_out);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] e;
        logic [7:0] req[3];
        logic       rst[3];
        req = '{8'd100, 8'd0, 8'd100};
        rst = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(rst[i], 16'd32767, 16'd32767);
            e = exp_q.pop_front();
            compared++;
            if (G_out !== e || G_out !== req[i]) begin
                mismatched++;
                $display("FAIL mid_reset[%0d]: got %0d expected %0d", i, G_out, req[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Changing inputs every cycle: each result reflects only its own cycle.
        test_vectors("back_to_back",
                     '{16'd20000, 16'd10000, 16'd1, 16'd30000, 16'd32767},
                     '{16'd10000, 16'd30000, 16'd0, 16'd14999, 16'd16384},
                     '{8'd50, 8'd100, 8'd0, 8'd49, 8'd50});
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        S_w   = 16'd0;
        S_wg  = 16'd0;

        test_reset();
        test_nominal();
        test_truncation();
        test_saturation();
        test_random();
        test_mid_reset();
        test_back_to_back();

        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/defuzz.md
Name: defuzz

Overview:
Output stage of the fuzzy controller. It converts the weighted-sum pair from rule aggregation into a crisp integer percentage.
- S_w: sum of rule weights, Q1.15.
- S_wg: sum of weight × consequent, Q1.15.
- Result: G = S_wg / max(S_w, EPS) × 100, truncated and clamped to 0..100, delivered as a registered uint8.
- The divide is safe when S_w ≈ 0.

Parameters:
- EPS, 16'd1: denominator floor in Q1.15 LSBs; S_w below EPS is replaced by EPS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- S_w  in  16  weight sum, unsigned Q1.15; full 0..65535 range accepted.
- S_wg  in  16  weighted consequent sum, unsigned Q1.15; full 0..65535 range accepted.
- G_out  out  8  crisp output, unsigned integer percent 0..100; registered.

Behaviour:
- Interface (decided): one clock domain (clk); reset rst_n is synchronous and active-low.
- Reset:
  - On any rising edge of clk with rst_n=0, G_out <= 0.
  - The reset value holds from the first reset edge onward.
  - Reset asserted mid-operation overrides the computed value on that edge.
- Latency: one cycle.
  - Inputs stable before rising edge N are reflected in G_out just after edge N.
  - No handshake or valid signal; a new result is computed every cycle.
- Data path, all unsigned, integer truncation throughout:
  - den = (S_w < EPS) ? EPS : S_w (16 bits).
  - num = S_wg zero-extended and shifted left 15 (31 bits).
  - ratio = floor(num / den), in Q1.15 (up to 31 bits). The divider is combinational; restoring/long-division structure is acceptable.
  - pct = floor(ratio × 100 / 2^15). The product uses at least 38 bits; no intermediate overflow or wrap is allowed.
  - G_out next = (pct > 100) ? 100 : pct[7:0].
- Boundary conditions:
  - S_w=0, S_wg=0 → 0 (the EPS path with a zero numerator).
  - S_w < EPS with S_wg > 0 → large ratio → clamps to 100.
  - S_wg > S_w → ratio > 1.0 → clamps to 100.
  - ratio exactly 1.0 (S_wg = S_w ≠ 0) → 100.
  - G_out never exceeds 100 and never contains X after the first reset edge.

Test Plan:
- Reset and zero input:
  - Hold rst_n=0 for 2 edges with S_w=S_wg=0 → G_out=0.
  - Release reset, apply S_w=0, S_wg=0 → G_out=0 after 1 edge.
- Nominal ratios:
  - (S_w=32767, S_wg=16384) → 50.
  - (32767, 32767) → 100.
  - (20000, 10000) → 50.
- Truncation edges:
  - (30000, 14999) → 49, via ratio 16382.
  - (30000, 15000) → 50, via ratio 16384.
- Saturation and tiny denominator:
  - (10000, 30000) → 100, with unclamped pct = 300.
  - (1, 32767) → 100.
  - (1, 0) → 0.
- Randomised sanity:
  - Apply ≥20 vectors with S_w random in 0..32767 and S_wg random in 0..S_w, driven at the falling edge and checked 1 cycle later.
  - Each G_out must equal the truncating reference formula above.
  - Each G_out must be ≤ 100.
- Mid-run reset: while G_out=100, assert rst_n=0 for one edge with inputs unchanged → G_out=0 on that edge, then 100 again one edge after release.
